rc4_sched: RTL and testbench

Top-level phase scheduler for the RC4 key search. It sequences the three S-memory engines, `load_mem`, shuffle and decrypt, for one candidate key at a time. It owns the single-port 256x8 S-memory and multiplexes its write/address port to whichever engine is active. It steps the candidate key until decrypt reports a pass or the key range is exhausted.

---
 rtl/rc4_sched_pkg.sv | 38 +++
 rtl/rc4_mem_mux.sv | 49 ++++
 rtl/rc4_sched.sv | 156 +++++++++++++++
 tb/tb_rc4_sched.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rc4_sched_pkg.sv
// rtl/rc4_sched_pkg.sv - shared types and constants for the RC4 key-search phase scheduler
package rc4_sched_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD_START = 4'd1,
        LOAD_WAIT  = 4'd2,
        SHUF_START = 4'd3,
        SHUF_WAIT  = 4'd4,
        DEC_START  = 4'd5,
        DEC_WAIT   = 4'd6,
        NEXT_KEY   = 4'd7,
        FOUND      = 4'd8,
        FAIL       = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LOAD = 2'd1,
        GNT_SHUF = 2'd2,
        GNT_DEC  = 2'd3
    } grant_t;

    // Which engine owns the S-memory port in a given scheduler state.
    function automatic grant_t grant_of(input state_t s);
        case (s)
            LOAD_START, LOAD_WAIT: grant_of = GNT_LOAD;
            SHUF_START, SHUF_WAIT: grant_of = GNT_SHUF;
            DEC_START, DEC_WAIT:   grant_of = GNT_DEC;
            default:               grant_of = GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_mem_mux.sv
// rtl/rc4_mem_mux.sv - combinational 3:1 S-memory request mux, zero output when nothing is granted
module rc4_mem_mux
    import rc4_sched_pkg::*;
(
    input  grant_t            i_grant,
    input  logic [ADDR_W-1:0] i_l_address,
    input  logic              i_l_wren,
    input  logic [DATA_W-1:0] i_l_data,
    input  logic [ADDR_W-1:0] i_s_address,
    input  logic              i_s_wren,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic [ADDR_W-1:0] i_d_address,
    input  logic              i_d_wren,
    input  logic [DATA_W-1:0] i_d_data,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_wren,
    output logic [DATA_W-1:0] o_data
);

    // Forward the granted engine's request; an ungranted port never writes.
    always_comb begin
        o_address = '0;
        o_wren    = 1'b0;
        o_data    = '0;
        case (i_grant)
            GNT_LOAD: begin
                o_address = i_l_address;
                o_wren    = i_l_wren;
                o_data    = i_l_data;
            end
            GNT_SHUF: begin
                o_address = i_s_address;
                o_wren    = i_s_wren;
                o_data    = i_s_data;
            end
            GNT_DEC: begin
                o_address = i_d_address;
                o_wren    = i_d_wren;
                o_data    = i_d_data;
            end
            default: begin
                o_address = '0;
                o_wren    = 1'b0;
                o_data    = '0;
            end
        endcase
    end

endmodule

// File: rtl/rc4_sched.sv
// rtl/rc4_sched.sv - RC4 key-search phase scheduler; optional per-phase watchdog via RC4_SCHED_TIMEOUT_EN
module rc4_sched
    import rc4_sched_pkg::*;
#(
    parameter int               KEY_W          = 24,
    parameter logic [KEY_W-1:0] KEY_START      = '0,
    parameter logic [KEY_W-1:0] KEY_END        = KEY_W'(24'h3FFFFF),
    parameter int               TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              l_start,
    input  logic              l_done,
    input  logic [ADDR_W-1:0] l_address,
    input  logic              l_wren,
    input  logic [DATA_W-1:0] l_data,
    output logic              s_start,
    input  logic              s_done,
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_wren,
    input  logic [DATA_W-1:0] s_data,
    output logic              d_start,
    input  logic              d_done,
    input  logic              d_pass,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_wren,
    input  logic [DATA_W-1:0] d_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    output logic [KEY_W-1:0]  key,
    output logic              busy,
    output logic              found,
    output logic              fail,
    output logic              timeout
);

    state_t           r_state;
    state_t           w_next;
    logic [KEY_W-1:0] r_key;
    logic             w_restart;
    logic             w_is_wait;
    logic             w_to_hit;

    assign w_restart = start && (r_state == IDLE || r_state == FOUND || r_state == FAIL);
    assign w_is_wait = (r_state == LOAD_WAIT) || (r_state == SHUF_WAIT) || (r_state == DEC_WAIT);

`ifdef RC4_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Watchdog: restarts at each engine kick-off and counts cycles spent waiting for done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == LOAD_START || r_state == SHUF_START || r_state == DEC_START) begin
            r_cnt <= '0;
        end else if (w_is_wait) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Limit is hit on the wait cycle whose increment would make the count equal TIMEOUT_CYCLES.
    assign w_to_hit = w_is_wait && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sticky timeout flag: set when a wait state gives up, cleared only by restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_restart) begin
            r_timeout <= 1'b0;
        end else if (w_is_wait && w_next == FAIL) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_to_hit = 1'b0;
    // Constant 0: the limit only matters when the watchdog is built.
    assign timeout  = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a done only counts in its own engine's wait state and beats the watchdog.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, FOUND, FAIL: if (start) w_next = LOAD_START;
            LOAD_START:        w_next = LOAD_WAIT;
            LOAD_WAIT: begin
                if (l_done)        w_next = SHUF_START;
                else if (w_to_hit) w_next = FAIL;
            end
            SHUF_START:        w_next = SHUF_WAIT;
            SHUF_WAIT: begin
                if (s_done)        w_next = DEC_START;
                else if (w_to_hit) w_next = FAIL;
            end
            DEC_START:         w_next = DEC_WAIT;
            DEC_WAIT: begin
                if (d_done)        w_next = d_pass ? FOUND : NEXT_KEY;
                else if (w_to_hit) w_next = FAIL;
            end
            NEXT_KEY:          w_next = (r_key == KEY_END) ? FAIL : LOAD_START;
            default:           w_next = IDLE;
        endcase
    end

    // Candidate key: rewinds on restart, steps only between attempts, never past KEY_END.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key <= KEY_START;
        end else if (w_restart) begin
            r_key <= KEY_START;
        end else if (r_state == NEXT_KEY && r_key != KEY_END) begin
            r_key <= r_key + KEY_W'(1);
        end
    end

    assign key     = r_key;
    assign l_start = (r_state == LOAD_START);
    assign s_start = (r_state == SHUF_START);
    assign d_start = (r_state == DEC_START);
    assign busy    = !(r_state == IDLE || r_state == FOUND || r_state == FAIL);
    assign found   = (r_state == FOUND);
    assign fail    = (r_state == FAIL);

    rc4_mem_mux u_mem_mux (
        .i_grant     (grant_of(r_state)),
        .i_l_address (l_address),
        .i_l_wren    (l_wren),
        .i_l_data    (l_data),
        .i_s_address (s_address),
        .i_s_wren    (s_wren),
        .i_s_data    (s_data),
        .i_d_address (d_address),
        .i_d_wren    (d_wren),
        .i_d_data    (d_data),
        .o_address   (mem_address),
        .o_wren      (mem_wren),
        .o_data      (mem_data)
    );

endmodule

// File: tb/tb_rc4_sched.sv
// tb/tb_rc4_sched.sv - self-checking bench for rc4_sched against a precomputed schedule timeline
module tb_rc4_sched;

    localparam int             KW      = 24;
    localparam logic [KW-1:0]  K_START = 24'h000000;
    localparam logic [KW-1:0]  K_END   = 24'h000006;
    localparam int             TO      = 16;
    localparam int             TMAX    = 512;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          l_start, l_done, l_wren;
    logic [7:0]    l_address, l_data;
    logic          s_start, s_done, s_wren;
    logic [7:0]    s_address, s_data;
    logic          d_start, d_done, d_pass, d_wren;
    logic [7:0]    d_address, d_data;
    logic [7:0]    mem_address, mem_data;
    logic          mem_wren;
    logic [KW-1:0] key;
    logic          busy, found, fail, timeout;

    int n_checks = 0;
    int n_errors = 0;
    int cur_c    = 0;

    // Expected schedule, indexed by cycle number since start was sampled.
    logic [2:0] tl_start [TMAX];
    logic [2:0] tl_done  [TMAX];
    int         tl_gnt   [TMAX];
    int         tl_key   [TMAX];
    int         t_final, final_kind, final_key, t_abort;
    logic       exp_timeout;

    always #5 clk = ~clk;

    rc4_sched #(
        .KEY_W(KW), .KEY_START(K_START), .KEY_END(K_END), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .l_start(l_start), .l_done(l_done), .l_address(l_address), .l_wren(l_wren), .l_data(l_data),
        .s_start(s_start), .s_done(s_done), .s_address(s_address), .s_wren(s_wren), .s_data(s_data),
        .d_start(d_start), .d_done(d_done), .d_pass(d_pass),
        .d_address(d_address), .d_wren(d_wren), .d_data(d_data),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data),
        .key(key), .busy(busy), .found(found), .fail(fail), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur_c, obs, exp);
        end
    endtask

    // Lay out the search as arithmetic on engine latencies: each phase is one START
    // cycle plus its latency, a failing key adds one NEXT_KEY cycle.
    task automatic build(input int pass_key, input int fixed_lat, input bit hang, input int abort_key);
        int t, lat;
        for (int i = 0; i < TMAX; i++) begin
            tl_start[i] = '0; tl_done[i] = '0; tl_gnt[i] = 0; tl_key[i] = 0;
        end
        t = 1;
        exp_timeout = 1'b0;
        t_abort = -1;
        for (int k = int'(K_START); k <= int'(K_END); k++) begin
            for (int e = 0; e < 3; e++) begin
                lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
                tl_start[t][e] = 1'b1;
                if (e == 1 && k == abort_key) t_abort = t + 1;
                if (hang && e == 2) begin
                    for (int i = t; i < TMAX; i++) begin tl_gnt[i] = 3; tl_key[i] = k; end
                    final_key = k;
`ifdef RC4_SCHED_TIMEOUT_EN
                    t_final = t + 1 + TO; final_kind = 1; exp_timeout = 1'b1;
`else
                    t_final = t + 41; final_kind = 2;
`endif
                    return;
                end
                for (int i = t; i <= t + lat; i++) begin tl_gnt[i] = e + 1; tl_key[i] = k; end
                tl_done[t + lat][e] = 1'b1;
                t = t + lat + 1;
            end
            tl_key[t] = k;
            if (k == pass_key) begin t_final = t; final_kind = 0; final_key = k; return; end
            t++;
            if (k == int'(K_END)) begin t_final = t; final_kind = 1; final_key = k; return; end
        end
    endtask

    task automatic drive_requests();
        l_address = 8'($urandom); l_data = 8'($urandom); l_wren = 1'($urandom_range(0, 1));
        s_address = 8'($urandom); s_data = 8'($urandom); s_wren = 1'($urandom_range(0, 1));
        d_address = 8'($urandom); d_data = 8'($urandom); d_wren = 1'($urandom_range(0, 1));
    endtask

    task automatic run_search(input int pass_key, input int fixed_lat, input bit hang, input int abort_key);
        int         last_c, gnt;
        bit         run;
        logic [2:0] dn;
        logic [16:0] exp_mem;
        build(pass_key, fixed_lat, hang, abort_key);
        @(negedge clk);
        drive_requests();
        l_done = 0; s_done = 0; d_done = 0; d_pass = 0;
        start = 1'b1;
        last_c = (final_kind == 2) ? t_final : t_final + 2;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            cur_c = c;
            start = 1'b0;
            drive_requests();
            run = (final_kind == 2) || (c < t_final);
            gnt = run ? tl_gnt[c] : 0;
            // Real dones come from the timeline; any engine not genuinely waiting gets noise.
            for (int e = 0; e < 3; e++) begin
                if (run && tl_done[c][e]) dn[e] = 1'b1;
                else if (run && tl_gnt[c] == e + 1 && !tl_start[c][e]) dn[e] = 1'b0;
                else dn[e] = ($urandom_range(0, 3) == 0);
            end
            l_done = dn[0]; s_done = dn[1]; d_done = dn[2];
            d_pass = (run && tl_done[c][2]) ? (tl_key[c] == pass_key) : 1'($urandom_range(0, 1));
            if (c == t_abort) s_wren = 1'b1;
            #1;
            chk("l_start", l_start, run && tl_start[c][0]);
            chk("s_start", s_start, run && tl_start[c][1]);
            chk("d_start", d_start, run && tl_start[c][2]);
            chk("busy", busy, run);
            chk("found", found, !run && final_kind == 0);
            chk("fail", fail, !run && final_kind == 1);
            chk("timeout", timeout, !run && exp_timeout);
            chk("key", key, run ? tl_key[c] : final_key);
            case (gnt)
                1:       exp_mem = {l_address, l_wren, l_data};
                2:       exp_mem = {s_address, s_wren, s_data};
                3:       exp_mem = {d_address, d_wren, d_data};
                default: exp_mem = '0;
            endcase
            chk("mem_port", {mem_address, mem_wren, mem_data}, exp_mem);
            if (c == t_abort) begin
                reset = 1'b1;
                #1;
                chk("abort_mem_wren", mem_wren, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_s_start", s_start, 1'b0);
                chk("abort_key", key, K_START);
                @(negedge clk);
                reset = 1'b0;
                #1;
                chk("abort_idle_l_start", l_start, 1'b0);
                chk("abort_idle_busy", busy, 1'b0);
                return;
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        l_done = 0; s_done = 0; d_done = 0; d_pass = 0;
        drive_requests();
        #1;
        cur_c = 0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_l_start", l_start, 1'b0);
        chk("rst_mem_wren", mem_wren, 1'b0);
        chk("rst_key", key, K_START);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        // Stray dones in IDLE must not launch anything.
        l_done = 1; s_done = 1; d_done = 1; d_pass = 1;
        @(negedge clk);
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_found", found, 1'b0);
        chk("idle_mem", {mem_address, mem_wren, mem_data}, 17'd0);

        run_search(0, 3, 1'b0, -1);   // pass on first key, fixed latency 3
        run_search(5, 0, 1'b0, -1);   // pass at key 5, random latencies
        run_search(-1, 0, 1'b0, -1);  // never passes: exhaust to KEY_END
        run_search(-1, 0, 1'b0, 2);   // restart from FAIL, reset mid SHUF_WAIT of key 2
        for (int i = 0; i < 4; i++)
            run_search(int'($urandom_range(0, 7)), 0, 1'b0, -1);
        run_search(-1, 0, 1'b0, int'(K_END)); // latest-key abort
        run_search(-1, 1, 1'b1, -1);  // decrypt never answers

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("final_timeout_clear", timeout, 1'b0);
        chk("final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
